// File: rtl/bcd_pkg.sv
// Shared constants and the BCD digit type for the binary-to-BCD converter.
package bcd_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADD3_VAL = 4'd3;
  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;
endpackage

// File: rtl/binary_to_bcd_if.sv
// Value/digit bundle between the value source and the 7-segment mux side.
interface binary_to_bcd_if;
  import bcd_pkg::*;
  logic [7:0] binary_in;
  bcd_digit_t H;
  bcd_digit_t T;
  bcd_digit_t O;
  modport master (output binary_in, input H, T, O);
  modport slave  (input binary_in, output H, T, O);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);
  assign q = (d >= BCD_ADD3_THRESH) ? d + BCD_ADD3_VAL : d;
endmodule

// File: rtl/binary_to_bcd.sv
// 8-bit binary to 3-digit BCD, registered outputs. Optional input register
// when BINARY_TO_BCD_INREG_EN is defined (latency 2 instead of 1).
module binary_to_bcd
  import bcd_pkg::*;
(
  input logic           clk,
  input logic           reset,
  binary_to_bcd_if.slave bus
);
  logic [7:0] conv_in;

`ifdef BINARY_TO_BCD_INREG_EN
  logic [7:0] in_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) in_q <= '0;
    else       in_q <= bus.binary_in;
  assign conv_in = in_q;
`else
  assign conv_in = bus.binary_in;
`endif

  // Digit values entering each stage; stage s shifts in conv_in[7-s].
  bcd_digit_t h [0:8];
  bcd_digit_t t [0:8];
  bcd_digit_t o [0:8];
  logic [7:0] unused_h_msb;

  assign h[0] = '0;
  assign t[0] = '0;
  assign o[0] = '0;

  for (genvar s = 0; s < 8; s++) begin : g_stage
    bcd_digit_t t_adj;
    bcd_digit_t o_adj;
    bcd_add3 u_t (.d(t[s]), .q(t_adj));
    bcd_add3 u_o (.d(o[s]), .q(o_adj));
    // Hundreds tops out at 2, so it never needs correction and its MSB stays 0.
    assign h[s+1] = {h[s][2:0], t_adj[3]};
    assign t[s+1] = {t_adj[2:0], o_adj[3]};
    assign o[s+1] = {o_adj[2:0], conv_in[7-s]};
    assign unused_h_msb[s] = h[s][3];
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.H <= '0;
      bus.T <= '0;
      bus.O <= '0;
    end else begin
      bus.H <= h[8];
      bus.T <= t[8];
      bus.O <= o[8];
    end
endmodule

// File: tb/tb_binary_to_bcd.sv
// Self-checking bench for binary_to_bcd against an arithmetic (div/mod) model.
module tb_binary_to_bcd;
  import bcd_pkg::*;

`ifdef BINARY_TO_BCD_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  binary_to_bcd_if bus ();
  binary_to_bcd dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Reference: which input value the outputs should currently show.
  logic [7:0] m_in, m_val;
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_in  <= 8'd0;
      m_val <= 8'd0;
    end else begin
      m_in  <= bus.binary_in;
      m_val <= (LAT == 2) ? m_in : bus.binary_in;
    end

  int exp_h, exp_t, exp_o;
  always_comb begin
    exp_h = int'(m_val) / 100;
    exp_t = (int'(m_val) / 10) % 10;
    exp_o = int'(m_val) % 10;
  end

  // Digits must always be legal BCD and hundreds must stay within 0..2.
  always @(negedge clk) begin
    checks++;
    if (bus.H > 4'd2 || bus.T > 4'd9 || bus.O > 4'd9) begin
      errors++;
      $display("FAIL range: got %0d/%0d/%0d required H<=2 T<=9 O<=9", bus.H, bus.T, bus.O);
    end
  end

  task automatic test_reset();
    bus.binary_in = 8'd173;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.H, bus.T, bus.O} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hold: got %0d/%0d/%0d required 0/0/0", bus.H, bus.T, bus.O);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    checks++;
    if ({bus.H, bus.T, bus.O} !== 12'h173) begin
      errors++;
      $display("FAIL reset_release: got %0d/%0d/%0d required 1/7/3", bus.H, bus.T, bus.O);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0]  vals [6] = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd255};
    logic [11:0] digs [6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h255};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk) bus.binary_in = vals[i];
      repeat (LAT) @(posedge clk);
      #1;
      checks++;
      if ({bus.H, bus.T, bus.O} !== digs[i]) begin
        errors++;
        $display("FAIL boundary_%0d: got %0d/%0d/%0d required %0h", vals[i],
                 bus.H, bus.T, bus.O, digs[i]);
      end
    end
  endtask

  task automatic test_latency();
    @(negedge clk) bus.binary_in = 8'd0;
    repeat (LAT + 1) @(posedge clk);
    @(negedge clk) bus.binary_in = 8'd200;
    #2;
    checks++;
    if ({bus.H, bus.T, bus.O} !== 12'h000) begin
      errors++;
      $display("FAIL latency_between_edges: got %0d/%0d/%0d required 0/0/0", bus.H, bus.T, bus.O);
    end
    for (int e = 1; e <= LAT; e++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.H, bus.T, bus.O} !== ((e == LAT) ? 12'h200 : 12'h000)) begin
        errors++;
        $display("FAIL latency_edge_%0d: got %0d/%0d/%0d required %s", e,
                 bus.H, bus.T, bus.O, (e == LAT) ? "2/0/0" : "0/0/0");
      end
    end
  endtask

  // Full 0..255 sweep, one value per cycle, with a 3-cycle reset pulse at 137.
  task automatic test_sweep_with_reset();
    for (int v = 0; v < 256; v++) begin
      @(negedge clk) begin
        bus.binary_in = 8'(v);
        if (v == 137) reset = 1'b1;
      end
      if (v == 137) begin
        #1;
        checks++;
        if ({bus.H, bus.T, bus.O} !== 12'h000) begin
          errors++;
          $display("FAIL sweep_reset_async: got %0d/%0d/%0d required 0/0/0", bus.H, bus.T, bus.O);
        end
        repeat (3) begin
          @(posedge clk);
          #1;
          checks++;
          if ({bus.H, bus.T, bus.O} !== 12'h000) begin
            errors++;
            $display("FAIL sweep_reset_held: got %0d/%0d/%0d required 0/0/0", bus.H, bus.T, bus.O);
          end
        end
        @(negedge clk) reset = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if (int'(bus.H) != exp_h || int'(bus.T) != exp_t || int'(bus.O) != exp_o ||
          $isunknown({bus.H, bus.T, bus.O})) begin
        errors++;
        $display("FAIL sweep_v%0d: got %0d/%0d/%0d required %0d/%0d/%0d", v,
                 bus.H, bus.T, bus.O, exp_h, exp_t, exp_o);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk) bus.binary_in = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      checks++;
      if (int'(bus.H) != exp_h || int'(bus.T) != exp_t || int'(bus.O) != exp_o ||
          $isunknown({bus.H, bus.T, bus.O})) begin
        errors++;
        $display("FAIL random_%0d: got %0d/%0d/%0d required %0d/%0d/%0d", i,
                 bus.H, bus.T, bus.O, exp_h, exp_t, exp_o);
      end
    end
  endtask

  initial begin
    bus.binary_in = 8'd0;
    test_reset();
    test_boundaries();
    test_latency();
    test_sweep_with_reset();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
